ee354_matrix_loader: RTL

Input stage for the 8x8 determinant engine. Accepts matrix elements one at a time, row-major, over a valid/ready handshake and assembles them into a full 8x8 array of signed words. Once the matrix is complete, it drives the engine's `Start`. It holds the array stable while the engine computes, then relays the user acknowledge so that both blocks return to idle together.

---
 rtl/ee354_matrix_loader_pkg.sv | 18 +
 rtl/ee354_matrix_loader_if.sv | 9 +
 rtl/ee354_matrix_store.sv | 28 ++
 rtl/ee354_matrix_loader.sv | 73 +++++++
 4 files changed

// File: rtl/ee354_matrix_loader_pkg.sv
// Shared constants for the 8x8 determinant path: matrix geometry, element
// index width and the loader's one-hot state encodings.
package ee354_pkg;
  localparam int N      = 8;
  localparam int W      = 32;
  localparam int IDX_W  = 6;
  localparam int NUM_EL = N * N;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EL - 1);

  // One-hot, bit order {Done, Run, Start, Fill, I}
  typedef logic [4:0] state_t;
  localparam state_t I     = 5'b00001;
  localparam state_t FILL  = 5'b00010;
  localparam state_t START = 5'b00100;
  localparam state_t RUN   = 5'b01000;
  localparam state_t DONE  = 5'b10000;
endpackage

// File: rtl/ee354_matrix_loader_if.sv
// Element stream into the loader: valid/ready with one signed word per beat.
interface ee354_matrix_loader_if #(parameter int W = 32);
  logic         In_valid;
  logic [W-1:0] In_data;
  logic         In_ready;

  modport master (output In_valid, output In_data, input  In_ready);
  modport slave  (input  In_valid, input  In_data, output In_ready);
endinterface

// File: rtl/ee354_matrix_store.sv
// 64-word element register file, one write port, whole array visible at once.
module ee354_matrix_store
  import ee354_pkg::*;
#(
  parameter int N = ee354_pkg::N,
  parameter int W = ee354_pkg::W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  output logic [N*N*W-1:0] mat
);
  logic [W-1:0] mem [N*N];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < N*N; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < N*N; k++) begin : g_flat
    assign mat[k*W +: W] = mem[k];
  end
endmodule

// File: rtl/ee354_matrix_loader.sv
// Collects a row-major 8x8 matrix, kicks the determinant engine, holds the
// array frozen while it runs and relays the operator acknowledge.
module ee354_matrix_loader
  import ee354_pkg::*;
#(
  parameter int N = ee354_pkg::N,
  parameter int W = ee354_pkg::W
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Load,
  input  logic                   Clear,
  ee354_matrix_loader_if.slave   in_if,
  output logic [N*N*W-1:0]       Mat_out,
  output logic                   Mat_valid,
  output logic [IDX_W-1:0]       Cnt,
  output logic                   Start,
  input  logic                   Det_done,
  input  logic                   User_ack,
  output logic                   Core_ack,
  output logic                   q_I,
  output logic                   q_Fill,
  output logic                   q_Start,
  output logic                   q_Run,
  output logic                   q_Done
);
  state_t state;
  logic   wr_en;

  assign {q_Done, q_Run, q_Start, q_Fill, q_I} = state;

  assign in_if.In_ready = q_Fill;
  assign Start          = q_Start;
  assign Mat_valid      = q_Start | q_Run | q_Done;
  assign Core_ack       = q_Done & User_ack;
  assign wr_en          = q_Fill & in_if.In_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= I;
      Cnt   <= '0;
    end else if (Clear) begin
      state <= I;
      Cnt   <= '0;
    end else begin
      case (state)
        I: begin
          Cnt <= '0;
          if (Load) state <= FILL;
        end
        FILL: if (in_if.In_valid) begin
          // The 6-bit count cannot represent 64, so it parks on the last
          // index instead of wrapping back to 0.
          if (Cnt == LAST_IDX) state <= START;
          else                 Cnt   <= Cnt + 1'b1;
        end
        START: state <= RUN;
        RUN:   if (Det_done) state <= DONE;
        DONE:  if (User_ack) state <= I;
        default: state <= I;
      endcase
    end
  end

  ee354_matrix_store #(.N(N), .W(W)) u_store (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (wr_en),
    .waddr (Cnt),
    .wdata (in_if.In_data),
    .mat   (Mat_out)
  );
endmodule
